// File: rtl/tx_intf_s_axis_pkg.sv
// rtl/tx_intf_s_axis_pkg.sv - ingress state encoding, clog2 helper and default widths
package tx_intf_s_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_NUM_QUEUE  = 4;
    localparam int DEF_QIDX_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH = 8192;
    localparam int DEF_CNT_WIDTH  = 14;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_intf_s_axis_mq_if.sv
// rtl/tx_intf_s_axis_mq_if.sv - AXI-Stream ingress bundle between the PS DMA and the queue buffer
interface tx_intf_s_axis_mq_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                  S_AXIS_TVALID;
    logic                  S_AXIS_TLAST;
    logic                  S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA,
        output S_AXIS_TVALID,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA,
        input  S_AXIS_TVALID,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/tx_intf_fifo_fwft.sv
// rtl/tx_intf_fifo_fwft.sv - single-clock first-word-fall-through FIFO with inferred RAM and flush
module tx_intf_fifo_fwft
    import tx_intf_s_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count
);
    localparam int ADDR_WIDTH = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  FULL_COUNT = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    // Head entry is presented straight from the RAM so a write shows up the next cycle.
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= next_addr(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= next_addr(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/tx_intf_s_axis_mq.sv
// rtl/tx_intf_s_axis_mq.sv - multi-queue AXIS ingress buffer with length enforcement and drain
// TX_INTF_S_AXIS_PKT_CNT_EN adds rd_last and per-queue complete-packet counts on pkt_count.
module tx_intf_s_axis_mq
    import tx_intf_s_axis_pkg::*;
#(
    parameter int NUM_QUEUE            = DEF_NUM_QUEUE,
    parameter int QIDX_WIDTH           = DEF_QIDX_WIDTH,
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH            = DEF_CNT_WIDTH
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    tx_intf_s_axis_mq_if.slave                  s_axis,
    input  logic [QIDX_WIDTH-1:0]               wr_queue_idx,
    input  logic                                endless_mode,
    input  logic [CNT_WIDTH-1:0]                num_dma_symbol,
    input  logic [QIDX_WIDTH-1:0]               rd_queue_idx,
    input  logic                                rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
    output logic                                rd_emptyn,
    output logic [NUM_QUEUE*CNT_WIDTH-1:0]      data_count,
    input  logic [NUM_QUEUE-1:0]                flush,
    output logic                                recv_busy,
    output logic                                overrun_pulse
`ifdef TX_INTF_S_AXIS_PKT_CNT_EN
    ,
    input  logic                                rd_last,
    output logic [NUM_QUEUE*8-1:0]              pkt_count
`endif
);
    state_t                          state;
    state_t                          state_nxt;
    logic [QIDX_WIDTH-1:0]           cur_q;
    logic [QIDX_WIDTH-1:0]           cur_q_nxt;
    logic [CNT_WIDTH-1:0]            len;
    logic [CNT_WIDTH-1:0]            len_nxt;
    logic [CNT_WIDTH-1:0]            beat_cnt;
    logic [CNT_WIDTH-1:0]            beat_cnt_nxt;
    logic [CNT_WIDTH-1:0]            req_len;
    logic [QIDX_WIDTH-1:0]           wr_q;
    logic                            wr_q_full;
    logic                            cur_flush;
    logic                            tready;
    logic                            accept;
    logic                            write_beat;
    logic                            overrun_nxt;
    logic [NUM_QUEUE-1:0]            fifo_empty;
    logic [NUM_QUEUE-1:0]            fifo_full;
    logic [NUM_QUEUE-1:0]            fifo_wr;
    logic [NUM_QUEUE-1:0]            fifo_rd;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_dout [NUM_QUEUE];

    // A zero length request still carries one beat.
    assign req_len = (num_dma_symbol == '0) ? CNT_WIDTH'(1) : num_dma_symbol;
    assign wr_q    = (state == IDLE) ? wr_queue_idx : cur_q;

    always_comb begin
        wr_q_full = 1'b0;
        cur_flush = 1'b0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (wr_q == QIDX_WIDTH'(q)) begin
                wr_q_full = fifo_full[q];
            end
            if (cur_q == QIDX_WIDTH'(q)) begin
                cur_flush = flush[q];
            end
        end
    end

    always_comb begin
        tready = 1'b0;
        if (S_AXIS_ARESETN) begin
            tready = (state == DRAIN) ? 1'b1 : !wr_q_full;
        end
    end

    assign s_axis.S_AXIS_TREADY = tready;
    assign accept               = s_axis.S_AXIS_TVALID && tready;

    always_comb begin
        state_nxt    = state;
        cur_q_nxt    = cur_q;
        len_nxt      = len;
        beat_cnt_nxt = beat_cnt;
        write_beat   = 1'b0;
        overrun_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cur_q_nxt    = wr_queue_idx;
                    len_nxt      = req_len;
                    beat_cnt_nxt = CNT_WIDTH'(1);
                    write_beat   = 1'b1;
                    if (!(s_axis.S_AXIS_TLAST || (!endless_mode && req_len == CNT_WIDTH'(1)))) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (cur_flush) begin
                    // The queue was emptied under us: throw away the rest of the packet.
                    write_beat = accept;
                    state_nxt  = (accept && s_axis.S_AXIS_TLAST) ? IDLE : DRAIN;
                end else if (accept) begin
                    write_beat   = 1'b1;
                    beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
                    if (s_axis.S_AXIS_TLAST) begin
                        state_nxt = IDLE;
                    end else if (!endless_mode && (beat_cnt + CNT_WIDTH'(1)) == len) begin
                        state_nxt   = DRAIN;
                        overrun_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis.S_AXIS_TLAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state         <= IDLE;
            cur_q         <= '0;
            len           <= '0;
            beat_cnt      <= '0;
            overrun_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cur_q         <= cur_q_nxt;
            len           <= len_nxt;
            beat_cnt      <= beat_cnt_nxt;
            overrun_pulse <= overrun_nxt;
        end
    end

    assign recv_busy = (state != IDLE);

    for (genvar q = 0; q < NUM_QUEUE; q++) begin : g_queue
        assign fifo_wr[q] = write_beat && (wr_q == QIDX_WIDTH'(q));
        assign fifo_rd[q] = rd_en && (rd_queue_idx == QIDX_WIDTH'(q));

        tx_intf_fifo_fwft #(
            .DATA_WIDTH (C_S_AXIS_TDATA_WIDTH),
            .DEPTH      (FIFO_DEPTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_fifo (
            .clk    (S_AXIS_ACLK),
            .resetn (S_AXIS_ARESETN),
            .flush  (flush[q]),
            .din    (s_axis.S_AXIS_TDATA),
            .wr_en  (fifo_wr[q]),
            .dout   (fifo_dout[q]),
            .rd_en  (fifo_rd[q]),
            .empty  (fifo_empty[q]),
            .full   (fifo_full[q]),
            .count  (data_count[q*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // An empty queue reads as zero so stale RAM contents never leak out.
    always_comb begin
        rd_data   = '0;
        rd_emptyn = 1'b0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (rd_queue_idx == QIDX_WIDTH'(q)) begin
                rd_emptyn = !fifo_empty[q];
                rd_data   = fifo_empty[q] ? '0 : fifo_dout[q];
            end
        end
    end

`ifdef TX_INTF_S_AXIS_PKT_CNT_EN
    logic pkt_done;

    assign pkt_done = accept && (
        (state == IDLE  && (s_axis.S_AXIS_TLAST || (!endless_mode && req_len == CNT_WIDTH'(1)))) ||
        (state == WRITE && !cur_flush &&
            (s_axis.S_AXIS_TLAST || (!endless_mode && (beat_cnt + CNT_WIDTH'(1)) == len))));

    for (genvar q = 0; q < NUM_QUEUE; q++) begin : g_pkt_cnt
        logic [7:0] cnt;
        logic       inc;
        logic       dec;

        assign inc = pkt_done && (wr_q == QIDX_WIDTH'(q));
        assign dec = fifo_rd[q] && rd_last && (cnt != 8'd0);

        always_ff @(posedge S_AXIS_ACLK) begin
            if (!S_AXIS_ARESETN || flush[q]) begin
                cnt <= 8'd0;
            end else if (inc && !dec && cnt != 8'hff) begin
                cnt <= cnt + 8'd1;
            end else if (dec && !inc) begin
                cnt <= cnt - 8'd1;
            end
        end

        assign pkt_count[q*8 +: 8] = cnt;
    end
`endif

endmodule

// File: tb/tb_tx_intf_s_axis_mq.sv
// tb/tb_tx_intf_s_axis_mq.sv - directed and randomized packets checked against a packet-level queue model
module tb_tx_intf_s_axis_mq;
    localparam int NQ    = 4;
    localparam int QW    = 2;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tx_intf_s_axis_mq_if #(.DATA_WIDTH(DW)) s_axis ();

    logic [QW-1:0]    wr_queue_idx = '0;
    logic [QW-1:0]    rd_queue_idx = '0;
    logic             endless_mode = 1'b0;
    logic             rd_en = 1'b0;
    logic [CW-1:0]    num_dma_symbol = '0;
    logic [NQ-1:0]    flush = '0;
    logic [DW-1:0]    rd_data;
    logic             rd_emptyn;
    logic             recv_busy;
    logic             overrun_pulse;
    logic [NQ*CW-1:0] data_count;
`ifdef TX_INTF_S_AXIS_PKT_CNT_EN
    logic             rd_last = 1'b0;
    logic [NQ*8-1:0]  pkt_count;
`endif

    tx_intf_s_axis_mq #(
        .NUM_QUEUE            (NQ),
        .QIDX_WIDTH           (QW),
        .C_S_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .CNT_WIDTH            (CW)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (resetn),
        .s_axis         (s_axis),
        .wr_queue_idx   (wr_queue_idx),
        .endless_mode   (endless_mode),
        .num_dma_symbol (num_dma_symbol),
        .rd_queue_idx   (rd_queue_idx),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_emptyn      (rd_emptyn),
        .data_count     (data_count),
        .flush          (flush),
        .recv_busy      (recv_busy),
        .overrun_pulse  (overrun_pulse)
`ifdef TX_INTF_S_AXIS_PKT_CNT_EN
        ,
        .rd_last        (rd_last),
        .pkt_count      (pkt_count)
`endif
    );

    logic [DW-1:0] mq [NQ][$];
    int vectors = 0;
    int miscompares = 0;
    int pk_i = 0;
    int pk_n = 0;
    int pk_len = 0;
    int pk_q = 0;
    bit pk_flushed = 1'b0;
    bit exp_ovr = 1'b0;
    bit exp_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot(output bit accepted);
        int   dest;
        int   cur_len;
        bit   store;
        bit   tr;
        bit   was_writing;
        logic [DW-1:0] head;
        @(negedge clk);
        dest    = (pk_i == 0) ? int'(wr_queue_idx) : pk_q;
        cur_len = (pk_i == 0) ? ((num_dma_symbol == 0) ? 1 : int'(num_dma_symbol)) : pk_len;
        store   = !pk_flushed && (endless_mode || pk_i < cur_len);
        tr      = s_axis.S_AXIS_TREADY;
        if (s_axis.S_AXIS_TVALID)
            check("tready", 64'(tr), store ? 64'(mq[dest].size() < DEPTH) : 64'd1);
        head = (mq[rd_queue_idx].size() != 0) ? mq[rd_queue_idx][0] : '0;
        check("rd_emptyn", 64'(rd_emptyn), 64'(mq[rd_queue_idx].size() != 0));
        check("rd_data", rd_data, head);
        for (int q = 0; q < NQ; q++)
            check($sformatf("data_count[%0d]", q), 64'(data_count[q*CW +: CW]), 64'(mq[q].size()));
        check("overrun_pulse", 64'(overrun_pulse), 64'(exp_ovr));
        check("recv_busy", 64'(recv_busy), 64'(exp_busy));
        accepted = s_axis.S_AXIS_TVALID && tr;
        @(posedge clk);
        was_writing = pk_i > 0 && !pk_flushed && (endless_mode || pk_i < pk_len);
        exp_ovr = 1'b0;
        if (rd_en && mq[rd_queue_idx].size() != 0) void'(mq[rd_queue_idx].pop_front());
        if (accepted) begin
            if (pk_i == 0) begin
                pk_q   = dest;
                pk_len = cur_len;
            end
            pk_i++;
            if (store && !flush[dest]) mq[dest].push_back(s_axis.S_AXIS_TDATA);
            if (store && !flush[dest] && !endless_mode && pk_i == pk_len && pk_i < pk_n) exp_ovr = 1'b1;
        end
        for (int q = 0; q < NQ; q++)
            if (flush[q]) mq[q].delete();
        if (was_writing && flush[pk_q] && !(accepted && s_axis.S_AXIS_TLAST)) pk_flushed = 1'b1;
        if (accepted && pk_i == pk_n) begin
            pk_i = 0;
            pk_flushed = 1'b0;
        end
        exp_busy = pk_i > 0;
        #1;
    endtask

    // rd_mode: 0 no reads, 1 random reads, 2 pop the target queue once stalled, 3 always pop the target queue
    task automatic send_packet(input int q, input int n, input int len, input bit endless,
                               input int flush_after, input int rd_mode, input logic [DW-1:0] base);
        bit acc;
        int waits;
        pk_n = n;
        pk_i = 0;
        pk_flushed = 1'b0;
        endless_mode = endless;
        for (int i = 1; i <= n; i++) begin
            s_axis.S_AXIS_TVALID = 1'b1;
            s_axis.S_AXIS_TDATA  = (base != 0) ? base * DW'(i) : {$urandom, $urandom};
            s_axis.S_AXIS_TLAST  = (i == n);
            wr_queue_idx   = (i == 1) ? QW'(q) : QW'(q + i);
            num_dma_symbol = (i == 1) ? CW'(len) : CW'($urandom);
            waits = 0;
            acc = 1'b0;
            while (!acc && waits < 200) begin
                flush = (flush_after != 0 && i == flush_after + 1 && waits == 0) ? NQ'(1 << q) : '0;
                rd_en = 1'b0;
                if (rd_mode == 1) begin
                    rd_queue_idx = QW'($urandom);
                    rd_en = 1'($urandom_range(0, 1));
                end else if ((rd_mode == 2 && waits >= 2) || rd_mode == 3) begin
                    rd_queue_idx = QW'(q);
                    rd_en = 1'b1;
                end
                slot(acc);
                waits++;
            end
            flush = '0;
            rd_en = 1'b0;
            check("beat_accepted", 64'(acc), 64'd1);
            if (!acc) break;
        end
        s_axis.S_AXIS_TVALID = 1'b0;
        s_axis.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic idle(input int n, input bit rd, input int rq);
        bit acc;
        rd_queue_idx = QW'(rq);
        rd_en = rd;
        for (int i = 0; i < n; i++) slot(acc);
        rd_en = 1'b0;
    endtask

    initial begin
        int q;
        int n;
        int len;
        s_axis.S_AXIS_TVALID = 1'b0;
        s_axis.S_AXIS_TLAST  = 1'b0;
        s_axis.S_AXIS_TDATA  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", 64'(s_axis.S_AXIS_TREADY), 64'd0);
        check("reset_data_count", 64'(data_count), 64'd0);
        check("reset_rd_emptyn", 64'(rd_emptyn), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_recv_busy", 64'(recv_busy), 64'd0);
        check("reset_overrun", 64'(overrun_pulse), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Routing: four beats to queue 2, then read them back
        send_packet(2, 4, 4, 1'b0, 0, 0, 64'h11);
        idle(1, 1'b0, 2);
        idle(4, 1'b1, 2);
        idle(1, 1'b0, 2);

        // Length limit of 3 on a six-beat packet
        send_packet(1, 6, 3, 1'b0, 0, 0, 64'h0);
        idle(2, 1'b0, 1);
        idle(3, 1'b1, 1);

        // Endless mode into a depth-16 queue with pops only when stalled
        send_packet(0, 20, 5, 1'b1, 0, 2, 64'h0);
        idle(1, 1'b0, 0);
        idle(DEPTH, 1'b1, 0);

        // wr_queue_idx moves mid packet; everything stays in queue 0
        send_packet(0, 5, 5, 1'b0, 0, 0, 64'h0);
        idle(5, 1'b1, 0);

        // Flush the active queue after two beats, then a clean packet
        send_packet(0, 8, 8, 1'b0, 2, 0, 64'h0);
        idle(1, 1'b0, 0);
        send_packet(0, 3, 3, 1'b0, 0, 0, 64'h0);
        idle(3, 1'b1, 0);

        // Concurrent write and pop on queue 3, then a pop of empty queue 1
        send_packet(3, 5, 5, 1'b0, 0, 0, 64'h0);
        send_packet(3, 1, 1, 1'b0, 0, 3, 64'h0);
        idle(1, 1'b1, 1);
        idle(6, 1'b1, 3);

        for (int k = 0; k < 40; k++) begin
            q   = $urandom_range(0, NQ - 1);
            n   = $urandom_range(1, 10);
            len = (n == 1) ? $urandom_range(0, 3) : $urandom_range(2, 12);
            send_packet(q, n, len, ($urandom_range(0, 3) == 0), 0, 1, 64'h0);
            idle($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, NQ - 1));
        end

        // Reset with data still queued
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_tready", 64'(s_axis.S_AXIS_TREADY), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) mq[i].delete();
        pk_i = 0;
        pk_flushed = 1'b0;
        exp_ovr = 1'b0;
        exp_busy = 1'b0;
        idle(1, 1'b0, 0);
        resetn = 1'b1;
        send_packet(1, 2, 2, 1'b0, 0, 0, 64'h5);
        idle(3, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
